inst_encoder: RTL and testbench



---
 rtl/inst_encoder_if.sv | 38 +++
 rtl/inst_encoder.sv | 170 +++++++++++++++++
 tb/tb_inst_encoder.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Request/write-port bundle for inst_encoder.
//   start, req_*      : symbolic instruction requests from the program source
//   req_ready         : encoder can take a request this cycle
//   mem_we/addr/data  : inst_rom write port (registered)
//   word_count, busy, done, err_illegal, err_overflow : load status
// master = program source / observer, slave = encoder.
interface inst_encoder_if;
  logic        start;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_sa;
  logic [15:0] req_imm;
  logic        req_last;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [7:0]  word_count;
  logic        busy;
  logic        done;
  logic        err_illegal;
  logic        err_overflow;

  modport master (
    output start, req_valid, req_op, req_rd, req_rs, req_rt, req_sa, req_imm, req_last,
    input  req_ready, mem_we, mem_addr, mem_data, word_count, busy, done,
           err_illegal, err_overflow
  );

  modport slave (
    input  start, req_valid, req_op, req_rd, req_rs, req_rt, req_sa, req_imm, req_last,
    output req_ready, mem_we, mem_addr, mem_data, word_count, busy, done,
           err_illegal, err_overflow
  );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: turns symbolic instruction requests into 32-bit MIPS words and
// writes them to the inst_rom write port at consecutive byte addresses starting
// at BASE_ADDR, then appends PAD_NOPS zero words so the pipeline drains.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : inst_encoder_if.slave (start, request handshake, write port, status)
// Parameters: BASE_ADDR (first byte address), DEPTH (word capacity),
//   PAD_NOPS (trailing zero words, 0 = none).
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 64,
  parameter int          PAD_NOPS  = 4
) (
  input  logic          clk,
  input  logic          rst,
  inst_encoder_if.slave bus
);

  localparam logic [7:0] DEPTH_C = 8'(DEPTH);
  localparam logic [7:0] PAD_C   = 8'(PAD_NOPS);

  typedef enum logic [1:0] {IDLE, RUN, PAD, DONE} state_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic        last;
  } req_t;

  state_t      state;
  req_t        req;
  logic [31:0] next_addr;
  logic [7:0]  pad_cnt;
  logic [7:0]  word_count;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        done;
  logic        err_illegal;
  logic        err_overflow;
  logic        full;
  logic [31:0] enc_word;
  logic        enc_legal;

  assign req  = {bus.req_op, bus.req_rd, bus.req_rs, bus.req_rt, bus.req_sa,
                 bus.req_imm, bus.req_last};
  assign full = (word_count == DEPTH_C);

  // Field packing; unused fields are forced to zero, never passed through.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (req.op)
      5'd0:  enc_word = 32'h0;
      5'd1:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'h0, 6'h25};
      5'd2:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'h0, 6'h24};
      5'd3:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'h0, 6'h26};
      5'd4:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'h0, 6'h27};
      5'd5:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'h0, 6'h04};
      5'd6:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'h0, 6'h06};
      5'd7:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'h0, 6'h07};
      5'd8:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'h0, 6'h0A};
      5'd9:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'h0, 6'h0B};
      5'd10: enc_word = {6'h00, 5'h0, req.rt, req.rd, req.sa, 6'h00};
      5'd11: enc_word = {6'h00, 5'h0, req.rt, req.rd, req.sa, 6'h02};
      5'd12: enc_word = {6'h00, 5'h0, req.rt, req.rd, req.sa, 6'h03};
      5'd13: enc_word = {16'h0, req.rd, 5'h0, 6'h10};
      5'd14: enc_word = {16'h0, req.rd, 5'h0, 6'h12};
      5'd15: enc_word = {6'h00, req.rs, 15'h0, 6'h11};
      5'd16: enc_word = {6'h00, req.rs, 15'h0, 6'h13};
      5'd17: enc_word = {21'h0, req.sa, 6'h0F};
      5'd18: enc_word = {6'h0D, req.rs, req.rt, req.imm};
      5'd19: enc_word = {6'h0C, req.rs, req.rt, req.imm};
      5'd20: enc_word = {6'h0E, req.rs, req.rt, req.imm};
      5'd21: enc_word = {6'h0F, 5'h0, req.rt, req.imm};
      5'd22: enc_word = {6'h33, req.rs, req.rt, req.imm};
      default: enc_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      next_addr    <= 32'h0;
      pad_cnt      <= 8'h0;
      word_count   <= 8'h0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_data     <= 32'h0;
      done         <= 1'b0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state        <= RUN;
          next_addr    <= BASE_ADDR;
          word_count   <= 8'h0;
          err_illegal  <= 1'b0;
          err_overflow <= 1'b0;
        end
        RUN: begin
          if (full) begin
            // A request offered with no room left ends the load.
            if (bus.req_valid) begin
              err_overflow <= 1'b1;
              state        <= DONE;
              done         <= 1'b1;
            end
          end else if (bus.req_valid) begin
            if (enc_legal) begin
              mem_we     <= 1'b1;
              mem_addr   <= next_addr;
              mem_data   <= enc_word;
              next_addr  <= next_addr + 32'd4;
              word_count <= word_count + 8'd1;
            end else begin
              // Illegal op is swallowed: no write, address unchanged.
              err_illegal <= 1'b1;
            end
            if (req.last) begin
              pad_cnt <= 8'h0;
              if (PAD_NOPS > 0) begin
                state <= PAD;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        PAD: begin
          // Exit is decided one cycle after the final pad write, so done
          // always trails the last write by exactly one cycle.
          if (full || pad_cnt == PAD_C) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            mem_we     <= 1'b1;
            mem_addr   <= next_addr;
            mem_data   <= 32'h0;
            next_addr  <= next_addr + 32'd4;
            word_count <= word_count + 8'd1;
            pad_cnt    <= pad_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state == RUN) && !full;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_data     = mem_data;
  assign bus.word_count   = word_count;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = done;
  assign bus.err_illegal  = err_illegal;
  assign bus.err_overflow = err_overflow;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder. Two instances share the request inputs and rst:
// dut0 (BASE 0, DEPTH 64, PAD 4) and dut1 (BASE 0x100, DEPTH 4, PAD 4); each
// has its own start, so only the started one consumes requests.
module tb_inst_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0, req_valid = 1'b0, req_last = 1'b0;
  logic [4:0]  req_op = '0, req_rd = '0, req_rs = '0, req_rt = '0, req_sa = '0;
  logic [15:0] req_imm = '0;

  inst_encoder_if i0();
  inst_encoder_if i1();

  assign i0.start = start0;       assign i1.start = start1;
  assign i0.req_valid = req_valid; assign i1.req_valid = req_valid;
  assign i0.req_op = req_op;       assign i1.req_op = req_op;
  assign i0.req_rd = req_rd;       assign i1.req_rd = req_rd;
  assign i0.req_rs = req_rs;       assign i1.req_rs = req_rs;
  assign i0.req_rt = req_rt;       assign i1.req_rt = req_rt;
  assign i0.req_sa = req_sa;       assign i1.req_sa = req_sa;
  assign i0.req_imm = req_imm;     assign i1.req_imm = req_imm;
  assign i0.req_last = req_last;   assign i1.req_last = req_last;

  inst_encoder #(.BASE_ADDR(32'h0), .DEPTH(64), .PAD_NOPS(4))
    dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
  inst_encoder #(.BASE_ADDR(32'h100), .DEPTH(4), .PAD_NOPS(4))
    dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [31:0] addr; logic [31:0] data;} wr_t;
  wr_t wq0[$], wq1[$], got[$];
  int dn0 = 0, dn1 = 0, dcyc0 = 0, dcyc1 = 0;

  // Write/done monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (i0.mem_we === 1'b1) wq0.push_back('{cyc, i0.mem_addr, i0.mem_data});
    if (i1.mem_we === 1'b1) wq1.push_back('{cyc, i1.mem_addr, i1.mem_data});
    if (i0.done === 1'b1) begin dn0 <= dn0 + 1; dcyc0 <= cyc; end
    if (i1.done === 1'b1) begin dn1 <= dn1 + 1; dcyc1 <= cyc; end
  end

  // Program under test
  logic [4:0]  p_op[32], p_rd[32], p_rs[32], p_rt[32], p_sa[32];
  logic [15:0] p_imm[32];
  bit          p_last[32];
  int          pn;

  // Results of the last load
  int          got_done, got_dcyc;
  logic [7:0]  got_wc;
  logic        got_ill, got_ovf;

  // Reference model outputs
  logic [63:0] exp_q[$];
  bit          exp_ill, exp_ovf, exp_padit;

  function automatic bit rdy(input bit s);
    return s ? i1.req_ready : i0.req_ready;
  endfunction
  function automatic bit bsy(input bit s);
    return s ? i1.busy : i0.busy;
  endfunction

  // Encoding table, written from the op list: {legal, word}.
  function automatic logic [32:0] ref_enc(input logic [4:0] op, rd, rs, rt, sa,
                                          input logic [15:0] imm);
    logic [5:0] rfun[9];
    logic [5:0] sfun[3];
    logic [5:0] iop[5];
    int k;
    rfun = '{6'h25, 6'h24, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07, 6'h0A, 6'h0B};
    sfun = '{6'h00, 6'h02, 6'h03};
    iop  = '{6'h0D, 6'h0C, 6'h0E, 6'h0F, 6'h33};
    k = int'(op);
    if (k == 0)  return {1'b1, 32'h0};
    if (k <= 9)  return {1'b1, 6'h00, rs, rt, rd, 5'h0, rfun[k-1]};
    if (k <= 12) return {1'b1, 11'h0, rt, rd, sa, sfun[k-10]};
    if (k <= 14) return {1'b1, 16'h0, rd, 5'h0, (k == 13) ? 6'h10 : 6'h12};
    if (k <= 16) return {1'b1, 6'h00, rs, 15'h0, (k == 15) ? 6'h11 : 6'h13};
    if (k == 17) return {1'b1, 21'h0, sa, 6'h0F};
    if (k <= 22) return {1'b1, iop[k-18], (k == 21) ? 5'h0 : rs, rt, imm};
    return {1'b0, 32'h0};
  endfunction

  // Whole-load model: list of expected (addr,data) writes and error flags.
  task automatic model_load(input bit s);
    int depth, cnt;
    logic [31:0] base;
    logic [32:0] r;
    bit ended;
    depth = s ? 4 : 64;
    base  = s ? 32'h100 : 32'h0;
    cnt = 0; ended = 0;
    exp_q.delete(); exp_ill = 0; exp_ovf = 0; exp_padit = 0;
    for (int i = 0; i < pn && !ended; i++) begin
      if (cnt == depth) begin
        exp_ovf = 1; ended = 1;
      end else begin
        r = ref_enc(p_op[i], p_rd[i], p_rs[i], p_rt[i], p_sa[i], p_imm[i]);
        if (r[32]) begin exp_q.push_back({base + 32'(4 * cnt), r[31:0]}); cnt++; end
        else exp_ill = 1;
        if (p_last[i]) begin ended = 1; exp_padit = 1; end
      end
    end
    if (exp_padit)
      for (int p = 0; p < 4 && cnt < depth; p++) begin
        exp_q.push_back({base + 32'(4 * cnt), 32'h0}); cnt++;
      end
  endtask

  task automatic drive_req(input int i);
    req_op = p_op[i]; req_rd = p_rd[i]; req_rs = p_rs[i]; req_rt = p_rt[i];
    req_sa = p_sa[i]; req_imm = p_imm[i]; req_last = p_last[i];
  endtask

  task automatic set_prog(input int i, input logic [4:0] op, rd, rs, rt, sa,
                          input logic [15:0] imm, input bit last);
    p_op[i] = op; p_rd[i] = rd; p_rs[i] = rs; p_rt[i] = rt; p_sa[i] = sa;
    p_imm[i] = imm; p_last[i] = last;
  endtask

  task automatic do_start(input bit s);
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  // Drop valid, wait (bounded) for the load to end, collect what was written.
  task automatic wait_idle(input bit s, input int base, input int dbase);
    int n;
    n = 0;
    req_valid = 1'b0;
    while (bsy(s) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL idle_timeout: dut%0d busy=%0b after %0d cycles, want busy=0", s, bsy(s), n);
    end
    @(negedge clk);
    got.delete();
    if (s) begin
      for (int k = base; k < wq1.size(); k++) got.push_back(wq1[k]);
      got_done = dn1 - dbase; got_dcyc = dcyc1;
      got_wc = i1.word_count; got_ill = i1.err_illegal; got_ovf = i1.err_overflow;
    end else begin
      for (int k = base; k < wq0.size(); k++) got.push_back(wq0[k]);
      got_done = dn0 - dbase; got_dcyc = dcyc0;
      got_wc = i0.word_count; got_ill = i0.err_illegal; got_ovf = i0.err_overflow;
    end
  endtask

  task automatic run_load(input bit s, input bit gaps, input bit poke);
    int base, dbase, n;
    bit stop;
    base  = s ? wq1.size() : wq0.size();
    dbase = s ? dn1 : dn0;
    do_start(s);
    stop = 0;
    for (int i = 0; i < pn && !stop; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin req_valid = 1'b0; @(negedge clk); end
      drive_req(i);
      req_valid = 1'b1;
      if (poke && i == 1) begin if (s) start1 = 1'b1; else start0 = 1'b1; end
      n = 0;
      while (!rdy(s) && bsy(s) && n < 200) begin @(negedge clk); n++; end
      if (!bsy(s)) stop = 1;
      else if (n >= 200) begin
        checks++; errors++; stop = 1;
        $display("FAIL ready_timeout: dut%0d req %0d ready=%0b, want 1", s, i, rdy(s));
      end else @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
    end
    wait_idle(s, base, dbase);
  endtask

  task automatic test_reset();
    logic [76:0] v0, v1;
    repeat (3) @(negedge clk);
    v0 = {i0.mem_we, i0.mem_addr, i0.mem_data, i0.word_count, i0.busy, i0.done,
          i0.err_illegal, i0.err_overflow};
    v1 = {i1.mem_we, i1.mem_addr, i1.mem_data, i1.word_count, i1.busy, i1.done,
          i1.err_illegal, i1.err_overflow};
    checks++; if (v0 !== '0) begin errors++; $display("FAIL reset_outputs0: got %h want 0", v0); end
    checks++; if (v1 !== '0) begin errors++; $display("FAIL reset_outputs1: got %h want 0", v1); end
    checks++; if (i0.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", i0.req_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    logic [31:0] w[6];
    w = '{32'h34011100, 32'h00221825, 32'h0, 32'h0, 32'h0, 32'h0};
    pn = 2;
    set_prog(0, 5'd18, 5'd0, 5'd0, 5'd1, 5'd0, 16'h1100, 0);
    set_prog(1, 5'd1, 5'd3, 5'd1, 5'd2, 5'd0, 16'h0, 1);
    run_load(0, 0, 0);
    checks++; if (got.size() != 6) begin errors++; $display("FAIL t1_nwrites: got %0d want 6", got.size()); end
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      checks++;
      if (got[k].addr !== 32'(4 * k) || got[k].data !== w[k]) begin
        errors++; $display("FAIL t1_word%0d: got %h@%h want %h@%h", k, got[k].data, got[k].addr, w[k], 32'(4 * k));
      end
    end
    checks++; if (got_wc !== 8'd6) begin errors++; $display("FAIL t1_word_count: got %0d want 6", got_wc); end
    checks++; if (got_done != 1) begin errors++; $display("FAIL t1_done_pulses: got %0d want 1", got_done); end
    if (got.size() > 0) begin
      checks++;
      if (got_dcyc != got[got.size()-1].cyc + 1) begin
        errors++; $display("FAIL t1_done_timing: got cycle %0d want %0d", got_dcyc, got[got.size()-1].cyc + 1);
      end
    end
  endtask

  task automatic test_encodings();
    logic [31:0] w[4];
    w = '{32'h00021200, 32'h0022200A, 32'h00002810, 32'h3C010101};
    pn = 4;
    // Junk in unused fields must not leak into the words.
    set_prog(0, 5'd10, 5'd2, 5'd9, 5'd2, 5'd8, 16'hFFFF, 0);
    set_prog(1, 5'd8, 5'd4, 5'd1, 5'd2, 5'd7, 16'h1234, 0);
    set_prog(2, 5'd13, 5'd5, 5'd3, 5'd6, 5'd9, 16'hABCD, 0);
    set_prog(3, 5'd21, 5'd7, 5'd7, 5'd1, 5'd3, 16'h0101, 1);
    run_load(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= got.size() || got[k].data !== w[k]) begin
        errors++; $display("FAIL t2_enc%0d: got %h want %h", k, (k < got.size()) ? got[k].data : 32'hx, w[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base, dbase;
    logic [31:0] w2;
    base = wq0.size(); dbase = dn0;
    w2 = 32'h34030033;
    do_start(0);
    for (int i = 0; i < 3; i++) begin
      req_op = 5'd18; req_rs = 5'd0; req_rt = 5'(i + 1); req_imm = 16'(8'h11 * (i + 1));
      req_last = 1'b0; req_valid = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (i0.mem_we !== 1'b0) begin errors++; $display("FAIL t3_bubble_we: got %b want 0", i0.mem_we); end
    checks++;
    if (i0.mem_addr !== 32'h8 || i0.mem_data !== w2) begin
      errors++; $display("FAIL t3_bubble_hold: got %h@%h want %h@%h", i0.mem_data, i0.mem_addr, w2, 32'h8);
    end
    req_op = 5'd0; req_last = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    req_last = 1'b0;
    wait_idle(0, base, dbase);
    checks++;
    if (got.size() < 4) begin errors++; $display("FAIL t3_nwrites: got %0d want >=4", got.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k].addr !== 32'(4 * k) || got[k].cyc != got[0].cyc + k) begin
          errors++; $display("FAIL t3_stream%0d: got addr %h cyc %0d want addr %h cyc %0d", k, got[k].addr, got[k].cyc, 32'(4 * k), got[0].cyc + k);
        end
      end
      checks++;
      if (got[3].cyc != got[2].cyc + 2 || got[3].addr !== 32'hC) begin
        errors++; $display("FAIL t3_after_gap: got addr %h cyc %0d want addr c cyc %0d", got[3].addr, got[3].cyc, got[2].cyc + 2);
      end
    end
  endtask

  task automatic test_depth_limit();
    for (int sc = 0; sc < 2; sc++) begin
      pn = (sc == 0) ? 4 : 5;
      for (int i = 0; i < pn; i++)
        set_prog(i, 5'd18, 5'd0, 5'd0, 5'(i), 5'd0, 16'(i), (sc == 0) && (i == 3));
      run_load(1, 0, 0);
      checks++; if (got.size() != 4) begin errors++; $display("FAIL t4_nwrites%0d: got %0d want 4", sc, got.size()); end
      for (int k = 0; k < 4 && k < got.size(); k++) begin
        checks++;
        if (got[k].addr !== 32'h100 + 32'(4 * k) || got[k].data !== (32'h34000000 | 32'(k << 16) | 32'(k))) begin
          errors++; $display("FAIL t4_word%0d_%0d: got %h@%h want %h@%h", sc, k, got[k].data, got[k].addr,
                             32'h34000000 | 32'(k << 16) | 32'(k), 32'h100 + 32'(4 * k));
        end
      end
      checks++; if (got_ovf !== 1'(sc)) begin errors++; $display("FAIL t4_overflow%0d: got %b want %0d", sc, got_ovf, sc); end
      checks++; if (got_done != 1) begin errors++; $display("FAIL t4_done%0d: got %0d want 1", sc, got_done); end
      checks++; if (got_wc !== 8'd4) begin errors++; $display("FAIL t4_word_count%0d: got %0d want 4", sc, got_wc); end
    end
  endtask

  task automatic test_illegal();
    int n;
    pn = 3;
    set_prog(0, 5'd18, 5'd0, 5'd0, 5'd1, 5'd0, 16'h0001, 0);
    set_prog(1, 5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'hFFFF, 0);
    set_prog(2, 5'd18, 5'd0, 5'd0, 5'd2, 5'd0, 16'h0002, 1);
    run_load(0, 0, 0);
    checks++; if (got_ill !== 1'b1) begin errors++; $display("FAIL t5_err_illegal: got %b want 1", got_ill); end
    checks++;
    if (got.size() < 2 || got[0].addr !== 32'h0 || got[0].data !== 32'h34010001 ||
        got[1].addr !== 32'h4 || got[1].data !== 32'h34020002) begin
      errors++; $display("FAIL t5_ori_placement: %0d writes, want 34010001@0 34020002@4", got.size());
    end
    checks++; if (got.size() != 6) begin errors++; $display("FAIL t5_nwrites: got %0d want 6", got.size()); end
    do_start(0);
    checks++; if (i0.err_illegal !== 1'b0) begin errors++; $display("FAIL t5_err_cleared: got %b want 0", i0.err_illegal); end
    req_op = 5'd0; req_last = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_last = 1'b0;
    n = 0;
    while (i0.busy && n < 50) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset_abort();
    logic [76:0] v;
    do_start(0);
    req_op = 5'd18; req_rt = 5'd4; req_imm = 16'h4444; req_last = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    v = {i0.mem_we, i0.mem_addr, i0.mem_data, i0.word_count, i0.busy, i0.done,
         i0.err_illegal, i0.err_overflow};
    checks++; if (v !== '0) begin errors++; $display("FAIL t6_rst_in_pad: got %h want 0", v); end
    rst = 1'b0;
    @(negedge clk);
    // start pulsed mid-load must leave the address sequence alone
    pn = 3;
    set_prog(0, 5'd19, 5'd0, 5'd2, 5'd3, 5'd0, 16'h00F0, 0);
    set_prog(1, 5'd3, 5'd6, 5'd4, 5'd5, 5'd0, 16'h0, 0);
    set_prog(2, 5'd17, 5'd0, 5'd0, 5'd0, 5'd5, 16'h0, 1);
    model_load(0);
    run_load(0, 0, 1);
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL t6_nwrites: got %0d want %0d", got.size(), exp_q.size()); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if ({got[k].addr, got[k].data} !== exp_q[k]) begin
        errors++; $display("FAIL t6_word%0d: got %h@%h want %h@%h", k, got[k].data, got[k].addr, exp_q[k][31:0], exp_q[k][63:32]);
      end
    end
  endtask

  task automatic test_random();
    bit s, nolast;
    for (int it = 0; it < 16; it++) begin
      s = it[0];
      pn = s ? $urandom_range(1, 7) : $urandom_range(1, 12);
      nolast = s && pn >= 5 && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < pn; i++) begin
        p_op[i] = (!nolast && $urandom_range(0, 3) == 0) ? 5'($urandom_range(23, 31))
                                                          : 5'($urandom_range(0, 22));
        p_rd[i] = 5'($urandom); p_rs[i] = 5'($urandom); p_rt[i] = 5'($urandom);
        p_sa[i] = 5'($urandom); p_imm[i] = 16'($urandom);
        p_last[i] = !nolast && (i == pn - 1);
      end
      model_load(s);
      run_load(s, 1, it == 4);
      checks++;
      if (got.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd%0d_nwrites: got %0d want %0d", it, got.size(), exp_q.size());
      end
      for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
        checks++;
        if ({got[k].addr, got[k].data} !== exp_q[k]) begin
          errors++; $display("FAIL rnd%0d_word%0d: got %h@%h want %h@%h", it, k, got[k].data, got[k].addr, exp_q[k][31:0], exp_q[k][63:32]);
        end
      end
      checks++; if (got_wc !== 8'(exp_q.size())) begin errors++; $display("FAIL rnd%0d_word_count: got %0d want %0d", it, got_wc, exp_q.size()); end
      checks++; if (got_ill !== exp_ill) begin errors++; $display("FAIL rnd%0d_err_illegal: got %b want %b", it, got_ill, exp_ill); end
      checks++; if (got_ovf !== exp_ovf) begin errors++; $display("FAIL rnd%0d_err_overflow: got %b want %b", it, got_ovf, exp_ovf); end
      checks++; if (got_done != 1) begin errors++; $display("FAIL rnd%0d_done: got %0d want 1", it, got_done); end
      if (exp_padit && got.size() > 0) begin
        checks++;
        if (got_dcyc != got[got.size()-1].cyc + 1) begin
          errors++; $display("FAIL rnd%0d_done_timing: got %0d want %0d", it, got_dcyc, got[got.size()-1].cyc + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_encodings();
    test_back_to_back();
    test_depth_limit();
    test_illegal();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
